// File: rtl/flash_read_ctrl.sv
// flash_read_ctrl
//   Issues a standard SPI READ (opcode 0x03 + 24-bit address) through the
//   flash_if pad stage and returns len bytes on a byte-wide valid strobe.
//
// Ports
//   clk_in    system clock (shared with flash_if)
//   rst_n     asynchronous active-low reset
//   start     one-cycle request, sampled only in IDLE
//   addr      flash byte address, latched with start
//   len       number of bytes to read, latched with start (0 = immediate done)
//   rx_q      serial read data from flash_if
//   busy      high from the cycle after acceptance until the end of the gap
//   rd_data   received byte (MSB first on the wire)
//   rd_valid  one-cycle strobe qualifying rd_data
//   done      one-cycle end-of-transaction strobe
//   clk_en    SCK pulse gate to flash_if, one per bit
//   cs_en     chip select to flash_if (high = selected)
//   sdi       serial command/address to flash_if
module flash_read_ctrl #(
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_GAP   = 4,
  parameter int unsigned RX_LAT   = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  input  logic             rx_q,
  output logic             busy,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             clk_en,
  output logic             cs_en,
  output logic             sdi
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [7:0]  OP_READ = 8'h03;

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, DRAIN, HOLD, GAP
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_val;
  logic               cnt_load;
  logic               accept, shift_bit, done_nx, cs_nx;
  logic [31:0]        tx_sr;
  logic [LEN_W-1:0]   byte_cnt;
  logic [4:0]         addr_cnt;
  logic               in_data;
  logic [2:0]         bit_cnt;
  logic [RX_LAT-1:0]  strb_pipe;
  logic [RX_LAT:0]    pipe_w;
  logic               dstb_pre, rx_sample;
  logic [6:0]         rx_sr;
  logic [2:0]         rx_bit;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    accept    = 1'b0;
    shift_bit = 1'b0;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            accept   = 1'b1;
            state_nx = SETUP;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(CS_SETUP - 1);
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nx  = SHIFT;
          shift_bit = 1'b1;
        end
      end
      SHIFT: begin
        if (!in_data && addr_cnt != 5'd31) shift_bit = 1'b1;
        if (in_data && bit_cnt == 3'd7 && byte_cnt == LEN_W'(1)) begin
          // The last data clk_en pulse lands in the first DRAIN cycle, so
          // RX_LAT cycles of DRAIN end exactly on the final rx sample.
          state_nx = DRAIN;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(RX_LAT - 1);
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          state_nx = HOLD;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(CS_HOLD - 1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nx = GAP;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(CS_GAP - 1);
          done_nx  = 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    cs_nx = state_nx inside {SETUP, SHIFT, DRAIN, HOLD};
    // Strobe computed one cycle ahead of clk_en so the pipe output lines up
    // with the posedge RX_LAT cycles after each data-phase clk_en cycle.
    dstb_pre  = (state == SHIFT) && in_data;
    pipe_w    = {strb_pipe, dstb_pre};
    rx_sample = pipe_w[RX_LAT];
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      tx_sr     <= '0;
      byte_cnt  <= '0;
      addr_cnt  <= '0;
      in_data   <= 1'b0;
      bit_cnt   <= '0;
      strb_pipe <= '0;
      rx_sr     <= '0;
      rx_bit    <= '0;
      busy      <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      clk_en    <= 1'b0;
      cs_en     <= 1'b0;
      sdi       <= 1'b0;
    end else begin
      if (cnt_load)        cnt <= cnt_val;
      else if (cnt != '0)  cnt <= cnt - 1'b1;

      if (accept) begin
        tx_sr    <= {OP_READ, addr};
        byte_cnt <= len;
        addr_cnt <= '0;
        in_data  <= 1'b0;
        bit_cnt  <= '0;
      end else if (shift_bit) begin
        tx_sr <= {tx_sr[30:0], 1'b0};
      end
      sdi <= shift_bit ? tx_sr[31] : 1'b0;

      if (state == SHIFT) begin
        if (!in_data) begin
          addr_cnt <= addr_cnt + 5'd1;
          if (addr_cnt == 5'd31) in_data <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_cnt <= byte_cnt - 1'b1;
        end
      end

      clk_en <= (state == SHIFT);
      cs_en  <= cs_nx;
      busy   <= (state_nx != IDLE);
      done   <= done_nx;

      strb_pipe <= pipe_w[RX_LAT-1:0];
      rd_valid  <= 1'b0;
      if (rx_sample) begin
        rx_sr  <= {rx_sr[5:0], rx_q};
        rx_bit <= rx_bit + 3'd1;
        if (rx_bit == 3'd7) begin
          rd_data  <= {rx_sr, rx_q};
          rd_valid <= 1'b1;
        end
      end
    end
  end

endmodule
